// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the execute/memory pipeline.
// Holds the ALU op codes used by the execute stage, the memory-op
// encodings, exception cause codes, bus widths, the memory-stage FSM
// state type and small decode helpers used by mem_stage.
package mem_stage_pkg;

  // Bus and register-file widths
  localparam int XLEN   = 32;
  localparam int BE_W   = XLEN / 8;
  localparam int REG_AW = 5;

  // ALU op codes (execute stage)
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;

  // Memory-op encodings; unlisted codes behave as MEM_NONE
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } memop_e;

  // Exception cause codes
  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_LD_MISAL = 2'd1;
  localparam logic [1:0] EXC_ST_MISAL = 2'd2;
  localparam logic [1:0] EXC_BUS_TMO  = 2'd3;

  // Memory-stage FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfword ops need an even address, word ops a word-aligned one
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic r;
    r = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: r = lo[0];
      MEM_LW, MEM_SW:          r = |lo;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational lane steering for the memory stage.
// Ports:
//   i_memop      memory-op code (mem_stage_pkg::memop_e encoding)
//   i_addr_lo    effective address bits [1:0]
//   i_store_data rs2 value for stores
//   i_rdata      read word from the data bus
//   o_be         byte enables (stores: lane mask, loads: all lanes)
//   o_store_data store data replicated across the lanes
//   o_load_data  extracted and sign/zero-extended load value
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]      i_memop,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [BE_W-1:0] o_be,
  output logic [XLEN-1:0] o_store_data,
  output logic [XLEN-1:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    // Halfword ops only reach here aligned, so addr[1] picks the half
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_be         = 4'b0000;
    o_store_data = '0;
    o_load_data  = '0;
    case (i_memop)
      MEM_LB:  begin o_be = 4'b1111; o_load_data = {{24{w_byte[7]}}, w_byte}; end
      MEM_LBU: begin o_be = 4'b1111; o_load_data = {24'd0, w_byte}; end
      MEM_LH:  begin o_be = 4'b1111; o_load_data = {{16{w_half[15]}}, w_half}; end
      MEM_LHU: begin o_be = 4'b1111; o_load_data = {16'd0, w_half}; end
      MEM_LW:  begin o_be = 4'b1111; o_load_data = i_rdata; end
      MEM_SB:  begin
        o_be         = 4'b0001 << i_addr_lo;
        o_store_data = {4{i_store_data[7:0]}};
      end
      MEM_SH:  begin
        o_be         = 4'b0011 << i_addr_lo;
        o_store_data = {2{i_store_data[15:0]}};
      end
      MEM_SW:  begin o_be = 4'b1111; o_store_data = i_store_data; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. Passes ALU results through, issues
// aligned loads/stores on the data bus and waits for the ack (bounded by
// ACK_TIMEOUT), and raises misalignment / bus-timeout exceptions.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_i/ready_o          upstream handshake
//   wd_i/wreg_i/wdata_i      dest reg, write enable, ALU result / address
//   memop_i, store_data_i    memory-op code, store operand
//   valid_o/wd_o/wreg_o/wdata_o  registered write-back result
//   stallreq_o               pipeline stall while a bus access is open
//   dbus_*                   data-bus request / response
//   exc_o, exc_cause_o       exception pulse and cause
//   dbg_state_o              current FSM state (0 IDLE, 1 BUS)
//
// Handshake: a transfer is taken on a rising edge where valid_i and
// ready_o are both 1; ready_o is high only in IDLE, and upstream keeps
// its inputs stable while ready_o is low.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [3:0]        memop_i,
  input  logic [XLEN-1:0]   store_data_i,
  output logic              valid_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              stallreq_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [XLEN-1:0]   dbus_addr_o,
  output logic [BE_W-1:0]   dbus_be_o,
  output logic [XLEN-1:0]   dbus_wdata_o,
  input  logic              dbus_ack_i,
  input  logic [XLEN-1:0]   dbus_rdata_i,
  output logic              exc_o,
  output logic [1:0]        exc_cause_o,
  output logic              dbg_state_o
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_memop;
  logic [1:0]        r_addr_lo;
  logic [REG_AW-1:0] r_wd_hold;
  logic              r_wreg_hold;

  logic              r_valid, r_wreg, r_exc, r_req, r_we;
  logic [REG_AW-1:0] r_wd;
  logic [XLEN-1:0]   r_wdata, r_addr, r_bwdata;
  logic [BE_W-1:0]   r_be;
  logic [1:0]        r_cause;

  logic              w_accept, w_is_mem, w_misal, w_ack, w_timeout;
  logic [3:0]        w_al_memop;
  logic [1:0]        w_al_addr_lo;
  logic [BE_W-1:0]   w_be;
  logic [XLEN-1:0]   w_st_data, w_ld_data;

  assign w_accept  = valid_i && (r_state == ST_IDLE);
  assign w_is_mem  = is_load(memop_i) || is_store(memop_i);
  assign w_misal   = is_misaligned(memop_i, wdata_i[1:0]);
  assign w_ack     = (r_state == ST_BUS) && dbus_ack_i;
  // The counter would reach ACK_TIMEOUT at this edge; an ack in the same
  // cycle takes priority.
  assign w_timeout = (r_state == ST_BUS) && !dbus_ack_i &&
                     (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

  // Lanes come from the incoming op while idle, from the held op on the bus
  assign w_al_memop   = (r_state == ST_BUS) ? r_memop   : memop_i;
  assign w_al_addr_lo = (r_state == ST_BUS) ? r_addr_lo : wdata_i[1:0];

  mem_align u_align (
    .i_memop      (w_al_memop),
    .i_addr_lo    (w_al_addr_lo),
    .i_store_data (store_data_i),
    .i_rdata      (dbus_rdata_i),
    .o_be         (w_be),
    .o_store_data (w_st_data),
    .o_load_data  (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_mem && !w_misal) w_state_nxt = ST_BUS;
      ST_BUS:  if (w_ack || w_timeout)                w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0; r_memop <= '0; r_addr_lo <= '0; r_wd_hold <= '0; r_wreg_hold <= 1'b0;
      r_valid <= 1'b0; r_wreg <= 1'b0; r_exc <= 1'b0; r_req <= 1'b0; r_we <= 1'b0;
      r_wd <= '0; r_wdata <= '0; r_addr <= '0; r_bwdata <= '0; r_be <= '0; r_cause <= '0;
    end else begin
      r_valid <= 1'b0;
      r_wreg  <= 1'b0;
      r_exc   <= 1'b0;
      if (w_accept) begin
        r_memop     <= memop_i;
        r_addr_lo   <= wdata_i[1:0];
        r_wd_hold   <= wd_i;
        r_wreg_hold <= wreg_i;
        if (!w_is_mem) begin
          r_valid <= 1'b1;
          r_wd    <= wd_i;
          r_wreg  <= wreg_i;
          r_wdata <= wdata_i;
        end else if (w_misal) begin
          r_valid <= 1'b1;
          r_wd    <= wd_i;
          r_exc   <= 1'b1;
          r_cause <= is_store(memop_i) ? EXC_ST_MISAL : EXC_LD_MISAL;
        end else begin
          r_req    <= 1'b1;
          r_we     <= is_store(memop_i);
          r_addr   <= {wdata_i[XLEN-1:2], 2'b00};
          r_be     <= w_be;
          r_bwdata <= w_st_data;
          r_cnt    <= '0;
        end
      end else if (r_state == ST_BUS) begin
        if (w_ack) begin
          r_req   <= 1'b0;
          r_valid <= 1'b1;
          r_wd    <= r_wd_hold;
          if (is_load(r_memop)) begin
            r_wreg  <= r_wreg_hold;
            r_wdata <= w_ld_data;
          end
        end else if (w_timeout) begin
          r_req   <= 1'b0;
          r_valid <= 1'b1;
          r_wd    <= r_wd_hold;
          r_exc   <= 1'b1;
          r_cause <= EXC_BUS_TMO;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign ready_o      = (r_state == ST_IDLE);
  assign stallreq_o   = (r_state == ST_BUS);
  assign dbg_state_o  = r_state;
  assign valid_o      = r_valid;
  assign wd_o         = r_wd;
  assign wreg_o       = r_wreg;
  assign wdata_o      = r_wdata;
  assign dbus_req_o   = r_req;
  assign dbus_we_o    = r_we;
  assign dbus_addr_o  = r_addr;
  assign dbus_be_o    = r_be;
  assign dbus_wdata_o = r_bwdata;
  assign exc_o        = r_exc;
  assign exc_cause_o  = r_cause;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases followed by randomized memory
// and ALU ops, each checked against a reference model computed from the
// architectural rules (sizes, masks, replication by multiplication).
module tb_mem_stage;

  localparam int TMO = 16;

  logic        clk, rst;
  logic        valid_i, ready_o;
  logic [4:0]  wd_i, wd_o;
  logic        wreg_i, wreg_o, valid_o, stallreq_o;
  logic [31:0] wdata_i, store_data_i, wdata_o;
  logic [3:0]  memop_i, dbus_be_o;
  logic        dbus_req_o, dbus_we_o, dbus_ack_i, exc_o, dbg_state_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [1:0]  exc_cause_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mem_stage #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .memop_i(memop_i),
    .store_data_i(store_data_i), .valid_o(valid_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i),
    .dbus_rdata_i(dbus_rdata_i), .exc_o(exc_o), .exc_cause_o(exc_cause_o),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after each edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    logic [31:0] e;
    e = exp_q.pop_front();
    chk("wb_data", wdata_o, e);
  endtask

  // ---------------- reference model ----------------
  // access size in bytes (0 = not a memory op)
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic bit op_signed(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2);
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input int lo, input logic [31:0] rd);
    int sz;
    logic [31:0] v;
    sz = op_size(op);
    v  = rd / (32'd1 << (8 * lo));
    if (sz == 4) return v;
    v = v % (32'd1 << (8 * sz));
    if (op_signed(op) && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input int lo);
    int m;
    if (!op_store(op)) return 4'hF;
    m = ((1 << op_size(op)) - 1) << lo;
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_sdata(input logic [3:0] op, input logic [31:0] sd);
    case (op_size(op))
      1:       return (sd % 32'h100) * 32'h0101_0101;
      2:       return (sd % 32'h1_0000) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  // ---------------- driver ----------------
  // ack_n: BUS cycle (1-based) in which ack is given; 0 means never
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] wd, input logic wreg, input int ack_n,
                        input logic [31:0] rdata);
    int sz, lo, stall;
    bit st, mis;
    sz  = op_size(op);
    lo  = int'(addr % 4);
    st  = op_store(op);
    mis = (sz == 2 && (lo % 2) == 1) || (sz == 4 && lo != 0);
    chk("ready_pre", ready_o, 1);
    valid_i = 1'b1; memop_i = op; wdata_i = addr; store_data_i = sd; wd_i = wd; wreg_i = wreg;
    step();
    valid_i = 1'b0;
    if (sz == 0) begin
      exp_q.push_back(addr);
      chk("alu_valid", valid_o, 1);
      chk("alu_wd", wd_o, 32'(wd));
      chk("alu_wreg", wreg_o, 32'(wreg));
      chk("alu_noreq", dbus_req_o, 0);
      chk("alu_noexc", exc_o, 0);
      sb_check();
    end else if (mis) begin
      chk("mis_valid", valid_o, 1);
      chk("mis_wreg", wreg_o, 0);
      chk("mis_exc", exc_o, 1);
      chk("mis_cause", exc_cause_o, st ? 2 : 1);
      chk("mis_noreq", dbus_req_o, 0);
      chk("mis_ready", ready_o, 1);
    end else begin
      chk("bus_req", dbus_req_o, 1);
      chk("bus_addr", dbus_addr_o, addr - 32'(lo));
      chk("bus_we", dbus_we_o, 32'(st));
      chk("bus_be", dbus_be_o, m_be(op, lo));
      if (st) chk("bus_wdata", dbus_wdata_o, m_sdata(op, sd));
      chk("bus_notready", ready_o, 0);
      stall = 0;
      if (ack_n > 0) begin
        for (int k = 1; k <= ack_n; k++) begin
          if (k == ack_n) begin
            dbus_ack_i = 1'b1; dbus_rdata_i = rdata;
          end else begin
            dbus_rdata_i = $urandom;
          end
          if (stallreq_o) stall++;
          if (k == ack_n) begin
            chk("bus_hold_req", dbus_req_o, 1);
            chk("bus_hold_addr", dbus_addr_o, addr - 32'(lo));
          end
          step();
        end
        dbus_ack_i = 1'b0;
        chk("ack_stall_len", stall, ack_n);
        chk("ack_valid", valid_o, 1);
        chk("ack_req_drop", dbus_req_o, 0);
        chk("ack_ready", ready_o, 1);
        chk("ack_noexc", exc_o, 0);
        chk("ack_wd", wd_o, 32'(wd));
        if (st) begin
          chk("st_wreg", wreg_o, 0);
        end else begin
          chk("ld_wreg", wreg_o, 32'(wreg));
          exp_q.push_back(m_load(op, lo, rdata));
          sb_check();
        end
      end else begin
        while (dbus_req_o && stall < 100) begin
          stall++;
          step();
        end
        chk("tmo_req_len", stall, TMO);
        chk("tmo_valid", valid_o, 1);
        chk("tmo_exc", exc_o, 1);
        chk("tmo_cause", exc_cause_o, 3);
        chk("tmo_wreg", wreg_o, 0);
        chk("tmo_ready", ready_o, 1);
      end
    end
    step();
    chk("pulse_valid", valid_o, 0);
    chk("pulse_exc", exc_o, 0);
    chk("pulse_wreg", wreg_o, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_wd"}, wd_o, 0);
    chk({tag, "_wreg"}, wreg_o, 0);
    chk({tag, "_wdata"}, wdata_o, 0);
    chk({tag, "_req"}, dbus_req_o, 0);
    chk({tag, "_we"}, dbus_we_o, 0);
    chk({tag, "_addr"}, dbus_addr_o, 0);
    chk({tag, "_be"}, dbus_be_o, 0);
    chk({tag, "_bwdata"}, dbus_wdata_o, 0);
    chk({tag, "_exc"}, exc_o, 0);
    chk({tag, "_cause"}, exc_cause_o, 0);
    chk({tag, "_ready"}, ready_o, 1);
    chk({tag, "_stall"}, stallreq_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    int          n;
    rst = 1'b1; valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    memop_i = '0; store_data_i = '0; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // ADD result pass-through
    run_op(4'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    // LB at 0x103, ack in third bus cycle
    run_op(4'd1, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 3, 32'h80FF_FF00);
    // SH at 0x202
    run_op(4'd7, 32'h0000_0202, 32'hAAAA_BEEF, 5'd0, 1'b0, 2, 32'h0);
    // LW misaligned
    run_op(4'd3, 32'h0000_0101, 32'h0, 5'd9, 1'b1, 0, 32'h0);
    // LHU with no ack -> bus timeout
    run_op(4'd5, 32'h0000_0402, 32'h0, 5'd3, 1'b1, 0, 32'h0);
    // ack on the last possible cycle still succeeds
    run_op(4'd2, 32'h0000_0502, 32'h0, 5'd4, 1'b1, TMO, 32'h8001_7FFF);
    // SH misaligned, SW misaligned, unused op code behaves as NONE
    run_op(4'd7, 32'h0000_0603, 32'h1234_5678, 5'd1, 1'b0, 0, 32'h0);
    run_op(4'd8, 32'h0000_0602, 32'h1234_5678, 5'd1, 1'b0, 0, 32'h0);
    run_op(4'd12, 32'hDEAD_BEEF, 32'h0, 5'd31, 1'b1, 0, 32'h0);

    // Reset in the middle of a bus access; a later ack is ignored
    valid_i = 1'b1; memop_i = 4'd3; wdata_i = 32'h0000_0300; wd_i = 5'd8; wreg_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("mid_req", dbus_req_o, 1);
    step(); step();
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    rst = 1'b0;
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hCAFE_F00D;
    step();
    dbus_ack_i = 1'b0;
    chk("late_ack_valid", valid_o, 0);
    chk("late_ack_req", dbus_req_o, 0);
    chk("late_ack_ready", ready_o, 1);
    step();
    chk("late_ack_valid2", valid_o, 0);

    // Randomized ops
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 10));
      a  = $urandom;
      n  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO);
      run_op(op, a, $urandom, 5'($urandom), 1'($urandom), n, $urandom);
    end

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, is the max cycles waited for dbus_ack_i before a bus-timeout exception.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 valid_i  in  1  execute-stage result valid.
REQ-005 ready_o  out  1  stage can accept; high exactly when state is IDLE.
REQ-006 wd_i / wreg_i / wdata_i  in  5/1/32  dest reg, write enable, ALU result (effective address for memory ops).
REQ-007 memop_i  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; other codes treated as NONE.
REQ-008 store_data_i  in  32  rs2 value for stores.
REQ-009 valid_o / wd_o / wreg_o / wdata_o  out  1/5/1/32  registered write-back result.
REQ-010 stallreq_o  out  1  pipeline stall request; high exactly when state is BUS.
REQ-011 dbus_req_o / dbus_we_o / dbus_addr_o / dbus_be_o / dbus_wdata_o  out  1/1/32/4/32  data-bus request.
REQ-012 dbus_ack_i / dbus_rdata_i  in  1/32  bus completion and read word.
REQ-013 exc_o / exc_cause_o  out  1/2  exception pulse; cause 1 load misaligned, 2 store misaligned, 3 bus timeout.

Function
REQ-014 A transfer is accepted on a rising edge with valid_i=1 and ready_o=1; upstream holds all inputs stable while ready_o=0.
REQ-015 States: IDLE, BUS; IDLE->BUS on accepting an aligned load/store; BUS->IDLE on dbus_ack_i=1 or timeout.
REQ-016 Non-memory op accepted: the next cycle gives valid_o=1, wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i (latency 1).
REQ-017 Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; byte ops are always aligned.
REQ-018 Misaligned accepted op: no bus request; the next cycle gives valid_o=1, wreg_o=0, exc_o=1 with the matching cause; state stays IDLE.
REQ-019 Aligned accepted op: the next cycle gives dbus_req_o=1, dbus_addr_o={addr[31:2],2'b00}, dbus_we_o=1 for stores only.
REQ-020 dbus_req_o and all dbus_* outputs stay constant through BUS until the ack cycle; dbus_req_o drops the cycle after ack.
REQ-021 Store byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads drive 4'b1111.
REQ-022 Store data: SB replicates byte 4x; SH replicates halfword 2x; SW passes the word.
REQ-023 Load data: extract the byte/halfword selected by addr[1:0] from dbus_rdata_i; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
REQ-024 On the ack cycle the result is registered: the next cycle gives valid_o=1, wdata_o=load value (stores: wreg_o=0), state IDLE.
REQ-025 Timeout counter clears on entering BUS and increments each BUS cycle without ack.
REQ-026 When the timeout counter reaches ACK_TIMEOUT: drop the request and return to IDLE; the next cycle gives valid_o=1, wreg_o=0, exc_o=1, cause 3.
REQ-027 Ack on the same cycle the counter reaches ACK_TIMEOUT counts as success; ack while IDLE is ignored.
REQ-028 valid_o and exc_o are single-cycle pulses; with valid_o=0, wreg_o=0 and the other outputs hold their last values.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, counter=0, all outputs 0 (valid_o, wreg_o, wd_o, wdata_o, dbus_*, exc_*).
REQ-030 Reset during BUS abandons the transaction immediately; a later ack is ignored.

Structure
REQ-031 memop encodings, exception cause codes and bus widths live in the shared define/package file alongside the existing ALU op codes.
REQ-032 Load extraction/sign-extension and store lane/byte-enable generation form one combinational sub-module, mem_align.

Verification
REQ-033 ADD result: wdata_i=0x1234, wd_i=5, memop NONE -> next cycle valid_o=1, wd_o=5, wdata_o=0x1234, no dbus_req_o.
REQ-034 LB at addr 0x103, ack after 3 cycles with rdata 0x80FF_FF00 -> dbus_addr_o=0x100, stallreq_o high 3 cycles, wdata_o=0xFFFF_FF80.
REQ-035 SH at addr 0x202 with store_data_i 0xAAAA_BEEF -> dbus_be_o=4'b1100, dbus_wdata_o=0xBEEF_BEEF, dbus_we_o=1, wreg_o=0.
REQ-036 LW at addr 0x101 -> no bus request, exc_o=1, exc_cause_o=1, wreg_o=0.
REQ-037 LHU with no ack, ACK_TIMEOUT=16 -> request held 16 cycles, then exc_cause_o=3, state IDLE.
REQ-038 rst asserted mid-BUS, then ack pulsed -> all outputs 0, ready_o=1, no valid_o from the abandoned op.
